// File: rtl/stepdown_pkg.sv
// Shared types and defaults for the stepdown PWM: FSM states and the
// width of the small dead-time / blanking timers.
package stepdown_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    LS_ON  = 3'd1,
    DT_L2H = 3'd2,
    HS_ON  = 3'd3,
    DT_H2L = 3'd4
  } state_e;

  localparam int DT_CYC_DEF    = 4;
  localparam int BLANK_CYC_DEF = 6;
  localparam int TMR_W         = 4;

  typedef logic [TMR_W-1:0] tmr_t;

endpackage

// File: rtl/stepdown_pwm_cnt.sv
// PWM period counter: wraps at period_q, and latches clamped period/duty
// either on leaving OFF or at every wrap so new settings start at cnt==0.
module stepdown_pwm_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             dem_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, duty_q, duty_d;
  logic [CNT_W-1:0] per_clamp, duty_clamp;

  // period 0 would make a zero-length cycle; treat it as 1
  always_comb begin
    per_clamp  = (period_i == '0) ? CNT_W'(1) : period_i;
    duty_clamp = (duty_i > per_clamp) ? per_clamp : duty_i;
  end

  assign wrap_o = run_i && (cnt_q == per_q);

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    duty_d = duty_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i || wrap_o) begin
      cnt_d  = '0;
      per_d  = per_clamp;
      duty_d = duty_clamp;
    end else if (run_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      per_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      duty_q <= duty_d;
    end
  end

  assign cnt_o = cnt_q;
  assign dem_o = cnt_q < duty_q;

endmodule

// File: rtl/stepdown_pwm_deadtime.sv
// PWM generator with dead-time insertion between high/low-side requests,
// leading-edge blanking and cycle-by-cycle over-current termination.
module stepdown_pwm_deadtime
  import stepdown_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DT_CYC    = DT_CYC_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic             CELCLK,
  input  logic             CELRST,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic             oc,
  output logic             hs_on,
  output logic             ls_on,
  output logic             cycle_start,
  output logic             oc_flag
);

  localparam tmr_t DT_LAST  = tmr_t'(DT_CYC - 1);
  localparam tmr_t BLANK_LD = tmr_t'(BLANK_CYC);

  state_e           state_q, state_d;
  tmr_t             dt_q, dt_d, blank_q, blank_d;
  logic             oc_lat_q, oc_lat_d, oc_flag_q;
  logic [CNT_W-1:0] cnt;
  logic             wrap, dem, hs_req, oc_acc;
  logic             unused_pins;

  assign unused_pins = CELV ^ CELG ^ SUB;

  stepdown_pwm_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i    (CELCLK),
    .rst_i    (CELRST),
    .clr_i    (state_d == OFF),
    .load_i   (state_q == OFF),
    .run_i    (state_q != OFF),
    .period_i (period),
    .duty_i   (duty),
    .cnt_o    (cnt),
    .wrap_o   (wrap),
    .dem_o    (dem)
  );

  assign hs_req = dem && !oc_lat_q;
  assign oc_acc = en && (state_q == HS_ON) && (blank_q == '0) && oc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     if (dt_q >= DT_LAST)     state_d = LS_ON;
      LS_ON:   if (hs_req)              state_d = DT_L2H;
      DT_L2H:  if (dt_q == DT_LAST)     state_d = HS_ON;
      HS_ON:   if (!hs_req || oc_acc)   state_d = DT_H2L;
      DT_H2L:  if (dt_q == DT_LAST)     state_d = LS_ON;
      default:                          state_d = OFF;
    endcase
    if (!en) state_d = OFF;
  end

  // dt_q counts cycles spent in the current state; it saturates so a long
  // OFF stretch cannot wrap back below the dead-time threshold
  always_comb begin
    dt_d     = (state_d != state_q) ? '0 :
               (dt_q == '1) ? dt_q : dt_q + tmr_t'(1);
    blank_d  = (state_d == HS_ON && state_q != HS_ON) ? BLANK_LD :
               (blank_q != '0) ? blank_q - tmr_t'(1) : '0;
    oc_lat_d = oc_lat_q;
    if (state_d == OFF || wrap) oc_lat_d = 1'b0;
    else if (oc_acc)            oc_lat_d = 1'b1;
  end

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state_q   <= OFF;
      dt_q      <= '0;
      blank_q   <= '0;
      oc_lat_q  <= 1'b0;
      oc_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dt_q      <= dt_d;
      blank_q   <= blank_d;
      oc_lat_q  <= oc_lat_d;
      oc_flag_q <= oc_acc;
    end
  end

  assign hs_on       = (state_q == HS_ON);
  assign ls_on       = (state_q == LS_ON);
  assign cycle_start = (state_q != OFF) && (cnt == '0);
  assign oc_flag     = oc_flag_q;

endmodule

// File: tb/tb_stepdown_pwm_deadtime.sv
// Bench for stepdown_pwm_deadtime: directed vector table, hand sequences for
// blanking/trip/duty-change/shutdown/reset, then random traffic vs a model.
module tb_stepdown_pwm_deadtime;

  localparam int DT    = 4;
  localparam int BLANK = 6;
  localparam int M_OFF = 0, M_LS = 1, M_DTU = 2, M_HS = 3, M_DTD = 4;

  logic       CELCLK = 1'b0;
  logic       CELRST, en, oc;
  logic [7:0] period, duty;
  logic       hs_on, ls_on, cycle_start, oc_flag;

  int n_chk = 0, n_fail = 0, cyc = 0;

  // behavioural reference: mode + time-in-mode instead of hardware timers
  int m_mode = M_OFF, m_age = 0, m_cnt = 0, m_per = 0, m_duty = 0;
  bit m_lat = 0, m_flag = 0;

  stepdown_pwm_deadtime #(.CNT_W(8), .DT_CYC(DT), .BLANK_CYC(BLANK)) dut (
    .CELCLK(CELCLK), .CELRST(CELRST), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .en(en), .period(period), .duty(duty), .oc(oc),
    .hs_on(hs_on), .ls_on(ls_on), .cycle_start(cycle_start), .oc_flag(oc_flag)
  );

  always #5 CELCLK = ~CELCLK;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    int nm, p, d;
    bit req, acc, wr;
    if (CELRST) begin
      m_mode = M_OFF; m_age = 0; m_cnt = 0; m_per = 0; m_duty = 0;
      m_lat = 0; m_flag = 0;
      return;
    end
    req = (m_cnt < m_duty) && !m_lat;
    acc = en && m_mode == M_HS && m_age >= BLANK && oc;
    wr  = m_mode != M_OFF && m_cnt == m_per;
    nm  = m_mode;
    if (!en) nm = M_OFF;
    else case (m_mode)
      M_OFF: if (m_age + 1 >= DT) nm = M_LS;
      M_LS:  if (req) nm = M_DTU;
      M_DTU: if (m_age + 1 == DT) nm = M_HS;
      M_HS:  if (!req || acc) nm = M_DTD;
      M_DTD: if (m_age + 1 == DT) nm = M_LS;
      default: nm = M_OFF;
    endcase
    if (nm == M_OFF || wr) m_lat = 0;
    else if (acc)          m_lat = 1;
    p = (period == 0) ? 1 : int'(period);
    d = (int'(duty) > p) ? p : int'(duty);
    if (nm == M_OFF) m_cnt = 0;
    else if (m_mode == M_OFF || wr) begin m_cnt = 0; m_per = p; m_duty = d; end
    else m_cnt++;
    m_age  = (nm != m_mode) ? 0 : m_age + 1;
    m_flag = acc;
    m_mode = nm;
  endtask

  task automatic tick();
    @(posedge CELCLK);
    model_step();
    @(negedge CELCLK);
    cyc++;
    chk("model_hs", hs_on, int'(m_mode == M_HS));
    chk("model_ls", ls_on, int'(m_mode == M_LS));
    chk("model_cs", cycle_start, int'(m_mode != M_OFF && m_cnt == 0));
    chk("model_flag", oc_flag, int'(m_flag));
    chk("no_overlap", int'(hs_on && ls_on), 0);
  endtask

  task automatic wait_cs(input string nm);
    int k = 0;
    while (!cycle_start && k < 200) begin tick(); k++; end
    chk(nm, cycle_start, 1);
  endtask

  task automatic wait_hs(input string nm);
    int k = 0;
    while (!hs_on && k < 200) begin tick(); k++; end
    chk(nm, hs_on, 1);
  endtask

  typedef struct {
    logic rst, en; logic [7:0] per, dty; logic oc;
    logic hs, ls, cs, fl;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int nh, k;
    bit seen;
    CELRST = 1; en = 0; period = 0; duty = 0; oc = 0;

    // period=9 duty=5: 4 OFF cycles, LS, 4 dead, 1 HS, 4 dead, LS ...
    tbl[0] = '{1, 0, 9, 5, 0, 0, 0, 0, 0};
    for (int i = 1; i < 16; i++) tbl[i] = '{0, 1, 9, 5, 0, 0, 0, 0, 0};
    tbl[4].ls = 1;  tbl[4].cs = 1;
    tbl[9].hs = 1;
    tbl[14].ls = 1; tbl[14].cs = 1;
    for (int i = 0; i < 16; i++) begin
      CELRST = tbl[i].rst; en = tbl[i].en; period = tbl[i].per;
      duty = tbl[i].dty; oc = tbl[i].oc;
      tick();
      chk($sformatf("vec%0d_hs", i), hs_on, tbl[i].hs);
      chk($sformatf("vec%0d_ls", i), ls_on, tbl[i].ls);
      chk($sformatf("vec%0d_cs", i), cycle_start, tbl[i].cs);
      chk($sformatf("vec%0d_flag", i), oc_flag, tbl[i].fl);
    end

    // blanking and cycle-by-cycle trip (period 20, duty 15)
    period = 20; duty = 15;
    wait_cs("sync_cs_a");
    wait_hs("sync_hs_a");
    tick();
    oc = 1; tick(); oc = 0;
    chk("oc_blanked_hs", hs_on, 1);
    chk("oc_blanked_flag", oc_flag, 0);
    repeat (4) tick();
    oc = 1; tick(); oc = 0;
    chk("oc_trip_hs", hs_on, 0);
    chk("oc_trip_flag", oc_flag, 1);
    tick();
    chk("oc_flag_once", oc_flag, 0);
    seen = 0; k = 0;
    while (!cycle_start && k < 50) begin seen |= hs_on; tick(); k++; end
    chk("oc_hold_off", int'(seen), 0);
    chk("oc_wrap_reached", cycle_start, 1);
    repeat (5) tick();
    chk("hs_after_oc_wrap", hs_on, 1);

    // duty change mid-period applies from next wrap only
    wait_cs("sync_cs_b");
    nh = hs_on;
    for (int i = 1; i <= 20; i++) begin
      if (i == 4) duty = 8;
      tick();
      nh += hs_on;
    end
    chk("duty_old_width", nh, 11);
    tick();
    chk("duty_wrap_cs", cycle_start, 1);
    nh = hs_on;
    for (int i = 1; i <= 20; i++) begin tick(); nh += hs_on; end
    chk("duty_new_width", nh, 4);
    tick();
    chk("duty_wrap_cs2", cycle_start, 1);

    // en dropped during HS_ON, then re-enabled
    wait_hs("sync_hs_c");
    en = 0; tick();
    chk("en_off_hs", hs_on, 0);
    chk("en_off_ls", ls_on, 0);
    en = 1;
    for (int i = 0; i < 3; i++) begin tick(); chk("off_hold_ls", ls_on, 0); end
    tick();
    chk("restart_ls", ls_on, 1);
    chk("restart_cs", cycle_start, 1);

    // reset during DT_L2H, then period=0 acts as period=1
    tick();
    chk("dt_before_rst", int'(hs_on | ls_on), 0);
    CELRST = 1; tick(); CELRST = 0;
    chk("rst_out", int'({hs_on, ls_on, cycle_start, oc_flag}), 0);
    period = 0; duty = 0;
    for (int i = 0; i < 3; i++) begin tick(); chk("rst_off_ls", ls_on, 0); end
    tick();
    chk("p0_ls", ls_on, 1);
    chk("p0_cs0", cycle_start, 1);
    tick();
    chk("p0_cs1", cycle_start, 0);
    tick();
    chk("p0_cs2", cycle_start, 1);

    // random traffic against the model
    period = 9; duty = 5;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) period = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) duty   = 8'($urandom_range(0, 14));
      en     = $urandom_range(0, 99) < 97;
      oc     = $urandom_range(0, 99) < 12;
      CELRST = $urandom_range(0, 299) == 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
